uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Direct-serial (rxd pin) 8N1 receiver with oversampled bit recovery and a
//   show-ahead receive FIFO. Sits between the board rxd pin and the CPU's
//   serial MMIO read path. The CPU polls data_ready, reads rd_data and pulses rd_en.
// PARAMETERS
//   CLK_FREQ    50_000_000  clk frequency, Hz
//   BAUD        115200      line rate, bit/s
//   OVERSAMPLE  16          ticks per bit; power of 2, >=8
//   FIFO_DEPTH  16          receive FIFO entries; power of 2
// PORTS
//   clk         in   1  system clock, single domain
//   rst         in   1  synchronous, active-high reset
//   rxd         in   1  asynchronous serial line, idle high
//   rd_en       in   1  pop one byte; ignored when FIFO empty
//   rd_data     out  8  head of FIFO (show-ahead), valid while data_ready=1
//   data_ready  out  1  FIFO not empty
//   fifo_full   out  1  FIFO holds FIFO_DEPTH bytes
//   overrun     out  1  sticky: a received byte was dropped on full FIFO
//   frame_err   out  1  sticky: stop bit sampled low
//   clr_err     in   1  clears overrun and frame_err
// BEHAVIOUR
//   Reset: all outputs 0; FIFO emptied; FSM to IDLE; rxd synchroniser flops = 1.
//   rxd passes a 2-flop synchroniser (2 clk latency) before any use.
//   Tick: DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)); free-running counter,
//     1-clk tick pulse every DIV clks; restarted on START entry for phase alignment.
//   FSM (sample counter 0..OVERSAMPLE-1 counts ticks within a bit):
//     IDLE  : synced rxd==0 -> START, counters cleared.
//     START : at tick OVERSAMPLE/2-1 (mid-bit): rxd==0 -> DATA; rxd==1 -> IDLE
//             (glitch rejected, nothing pushed, no flag).
//     DATA  : each mid-bit sample shifts in, LSB first; after bit 7 -> STOP.
//     STOP  : mid-bit sample; rxd==1 -> push byte (or set overrun if full) -> IDLE;
//             rxd==0 -> set frame_err, discard byte -> BREAK.
//     BREAK : wait for synced rxd==1, then IDLE (holds off on a break condition).
//   Latency: byte written into FIFO on the clk after the stop-bit sample;
//     data_ready rises the following clk.
//   FIFO: count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//     Push and pop in same clk: both happen, count unchanged (also when full:
//     the pop frees the slot, so no overrun). Pop on empty: no effect.
//     Push when full and no pop: byte dropped, overrun<=1, contents unchanged.
//   Sticky flags: set has priority over clr_err in the same clk.
//   Reset mid-frame: partial byte discarded, FSM IDLE; the next full frame after
//     rxd returns high is received normally.
// STRUCTURE
//   uart_defines.vh: FSM state encodings (IDLE, START, DATA, STOP, BREAK),
//     DIV computation macro, shared with the future uart_tx.
//   Sub-module: sync_fifo (DEPTH, WIDTH=8; push, pop, dout, empty, full, count).
//   Top: synchroniser, tick generator, FSM and shift register, flag logic.
// TESTING  (CLK_FREQ=50M, BAUD=115200, OVERSAMPLE=16 -> DIV=27, bit=432 clks)
//   Frame 0x55 -> data_ready=1 ~9.5 bit times after start edge, rd_data=0x55;
//     one rd_en pulse -> data_ready=0.
//   rxd low for 100 clks then high -> no push, no flags, FSM back in IDLE.
//   Frame 0xA3 with stop bit low -> frame_err=1, FIFO empty; line high ->
//     next frame 0x3C received; clr_err -> frame_err=0.
//   17 frames 0x00..0x10, no reads -> fifo_full=1, overrun=1; 16 reads return
//     0x00..0x0F in order; data_ready=0 afterwards.
//   Full FIFO, rd_en asserted on the clk of the 17th push -> overrun stays 0,
//     count stays 16. clr_err on the same clk as a new overrun -> overrun=1.
//   rst asserted mid-DATA of frame 0xFF -> all outputs 0; next frame 0x81 read as 0x81.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider math.
// Imported by the receive path today and the transmit path later.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Rounded clk cycles per oversample tick.
  function automatic int calc_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; a full-FIFO push only lands when
// a pop frees a slot in the same clock.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (do_pop && !do_push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with oversampled bit recovery feeding
// a show-ahead receive FIFO, plus sticky overrun/framing flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       data_ready,
  output logic       fifo_full,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clr_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  logic          rxd_s1_q, rxd_s2_q;
  logic          rxd_s;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick;
  rx_state_e     state_q, state_d;
  logic [SW-1:0] smp_cnt_q, smp_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          frame_set;
  logic          overrun_set;
  logic          pop;

  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_full_w;
  logic [CW-1:0] fifo_count;

  assign rxd_s = rxd_s2_q;
  assign tick  = (div_cnt_q == DW'(DIV - 1));
  assign pop   = rd_en && (fifo_count != '0);

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          // Restart the tick phase on the falling edge.
          state_d   = ST_START;
          smp_cnt_d = '0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (smp_cnt_q == MID) begin
            state_d   = rxd_s ? ST_IDLE : ST_DATA;
            smp_cnt_d = '0;
          end else begin
            smp_cnt_d = smp_cnt_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (smp_cnt_q == LAST) begin
            shift_d   = {rxd_s, shift_q[7:1]};
            smp_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_STOP;
          end else begin
            smp_cnt_d = smp_cnt_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (smp_cnt_q == LAST) begin
            smp_cnt_d = '0;
            if (rxd_s) begin
              push_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = ST_BREAK;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SW'(1);
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign overrun_set = push_q && fifo_full_w && !pop;

  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (clr_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_set)   frame_err_d = 1'b1;
    if (overrun_set) overrun_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      div_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_s1_q    <= rxd;
      rxd_s2_q    <= rxd_s1_q;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (shift_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full_w),
    .count (fifo_count)
  );

  assign rd_data    = fifo_empty ? 8'h00 : fifo_dout;
  assign data_ready = !fifo_empty;
  assign fifo_full  = fifo_full_w;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule
